// File: rtl/scoreboard_ctrl_pkg.sv
// scoreboard_ctrl_pkg
// Shared constants, FSM state encodings and helpers for the register
// scoreboard. Register file is 32 entries wide with x0 hard-wired to zero.
package scoreboard_ctrl_pkg;

  localparam int          RADDR_WIDTH  = 5;
  localparam int          NUM_REGS     = 32;
  localparam logic [4:0]  ZERO_REG     = 5'd0;
  localparam logic        READ_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_DRAIN = 2'd2
  } sb_state_e;

  // One-hot register select; x0 never maps to a bit so it can never be
  // marked pending or cleared.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [RADDR_WIDTH-1:0] r);
    logic [NUM_REGS-1:0] oh;
    oh = {NUM_REGS{1'b0}};
    if (r != ZERO_REG) begin
      oh[r] = 1'b1;
    end else begin
      oh = {NUM_REGS{1'b0}};
    end
    return oh;
  endfunction

endpackage

// File: rtl/scoreboard_ctrl_if.sv
// scoreboard_ctrl_if
// Groups the decode request, long-latency writeback, flush and scoreboard
// status signals.
//   master : decode/writeback side (drives requests, observes status)
//   slave  : scoreboard side (observes requests, drives status)
interface scoreboard_ctrl_if
  import scoreboard_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                   id_valid_i;
  logic                   id_reg1_re_i;
  logic                   id_reg2_re_i;
  logic [RADDR_WIDTH-1:0] id_reg1_raddr_i;
  logic [RADDR_WIDTH-1:0] id_reg2_raddr_i;
  logic                   id_reg_we_i;
  logic [RADDR_WIDTH-1:0] id_reg_waddr_i;
  logic                   id_long_i;
  logic                   id_fence_i;
  logic                   wb_long_we_i;
  logic [RADDR_WIDTH-1:0] wb_long_waddr_i;
  logic                   flush_i;
  logic                   stall_o;
  logic                   issue_o;
  logic [NUM_REGS-1:0]    pending_o;
  logic [CNT_W-1:0]       outstanding_o;

  modport master (
    output id_valid_i, id_reg1_re_i, id_reg2_re_i, id_reg1_raddr_i, id_reg2_raddr_i,
           id_reg_we_i, id_reg_waddr_i, id_long_i, id_fence_i,
           wb_long_we_i, wb_long_waddr_i, flush_i,
    input  stall_o, issue_o, pending_o, outstanding_o
  );

  modport slave (
    input  id_valid_i, id_reg1_re_i, id_reg2_re_i, id_reg1_raddr_i, id_reg2_raddr_i,
           id_reg_we_i, id_reg_waddr_i, id_long_i, id_fence_i,
           wb_long_we_i, wb_long_waddr_i, flush_i,
    output stall_o, issue_o, pending_o, outstanding_o
  );

endinterface

// File: rtl/scoreboard_ctrl_hazard_chk.sv
// hazard_chk
// Combinational RAW/WAW detection against the pending-write mask.
// A register being cleared by writeback this cycle is treated as ready.
//   reg1_re/reg2_re, reg1_raddr/reg2_raddr : source operand reads
//   reg_we, reg_waddr                       : destination write
//   pending, clr                            : pending mask and this-cycle clears
//   raw_hit, waw_hit                        : hazard flags
module hazard_chk
  import scoreboard_ctrl_pkg::*;
(
  input  logic                   reg1_re,
  input  logic                   reg2_re,
  input  logic [RADDR_WIDTH-1:0] reg1_raddr,
  input  logic [RADDR_WIDTH-1:0] reg2_raddr,
  input  logic                   reg_we,
  input  logic [RADDR_WIDTH-1:0] reg_waddr,
  input  logic [NUM_REGS-1:0]    pending,
  input  logic [NUM_REGS-1:0]    clr,
  output logic                   raw_hit,
  output logic                   waw_hit
);

  logic [NUM_REGS-1:0] busy_s;
  logic                raw1_s;
  logic                raw2_s;

  // Registers still busy once writeback forwarding is accounted for.
  assign busy_s = pending & ~clr;

  // Hazard evaluation; x0 is never a hazard.
  always_comb begin
    raw1_s  = (reg1_re == READ_ENABLE) && (reg1_raddr != ZERO_REG) && busy_s[reg1_raddr];
    raw2_s  = (reg2_re == READ_ENABLE) && (reg2_raddr != ZERO_REG) && busy_s[reg2_raddr];
    raw_hit = raw1_s || raw2_s;
    waw_hit = (reg_we == WRITE_ENABLE) && (reg_waddr != ZERO_REG) && busy_s[reg_waddr];
  end

endmodule

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl
// Tracks registers awaiting a long-latency writeback and stalls decode on
// RAW/WAW hazards, a full producer budget, or a fence with pending writes.
//   clk, rst : clock and asynchronous active-high reset
//   sb       : scoreboard_ctrl_if.slave (decode/writeback in, stall/issue/
//              pending mask/outstanding count out)
module scoreboard_ctrl
  import scoreboard_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  scoreboard_ctrl_if.slave      sb
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  sb_state_e           state_r, state_nxt_s;
  logic [NUM_REGS-1:0] pending_r, pending_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;

  logic [NUM_REGS-1:0] clr_s, set_s, after_clr_s;
  logic                any_clr_s, raw_hit_s, waw_hit_s, full_hit_s, drain_hit_s;
  logic                stall_s, issue_s, inc_s;

  // Only pending registers can clear; x0 is excluded by reg_onehot.
  assign clr_s       = sb.wb_long_we_i ? (pending_r & reg_onehot(sb.wb_long_waddr_i))
                                       : {NUM_REGS{1'b0}};
  assign any_clr_s   = |clr_s;
  assign after_clr_s = pending_r & ~clr_s;

  hazard_chk u_hazard_chk (
    .reg1_re    (sb.id_reg1_re_i),
    .reg2_re    (sb.id_reg2_re_i),
    .reg1_raddr (sb.id_reg1_raddr_i),
    .reg2_raddr (sb.id_reg2_raddr_i),
    .reg_we     (sb.id_reg_we_i),
    .reg_waddr  (sb.id_reg_waddr_i),
    .pending    (pending_r),
    .clr        (clr_s),
    .raw_hit    (raw_hit_s),
    .waw_hit    (waw_hit_s)
  );

  // Zero-latency stall/issue decision; a retiring producer frees a slot.
  always_comb begin
    full_hit_s  = sb.id_long_i && (cnt_r == CNT_MAX) && !any_clr_s;
    drain_hit_s = sb.id_fence_i && (after_clr_s != {NUM_REGS{1'b0}});
    stall_s     = sb.id_valid_i && !sb.flush_i &&
                  (raw_hit_s || waw_hit_s || full_hit_s || drain_hit_s);
    issue_s     = sb.id_valid_i && !sb.flush_i && !stall_s;
    inc_s       = issue_s && sb.id_long_i && (sb.id_reg_we_i == WRITE_ENABLE) &&
                  (sb.id_reg_waddr_i != ZERO_REG);
  end

  assign sb.stall_o       = stall_s;
  assign sb.issue_o       = issue_s;
  assign sb.pending_o     = pending_r;
  assign sb.outstanding_o = cnt_r;

  // Next pending mask and producer count. A set applied after clears lets a
  // new producer reuse a register retiring in the same cycle.
  always_comb begin
    set_s         = inc_s ? reg_onehot(sb.id_reg_waddr_i) : {NUM_REGS{1'b0}};
    pending_nxt_s = after_clr_s | set_s;
    cnt_nxt_s     = cnt_r;
    if (inc_s && !any_clr_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (any_clr_s && !inc_s && (cnt_r != CNT_ZERO)) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // FSM next-state; flush always returns to RUN.
  always_comb begin
    state_nxt_s = state_r;
    if (sb.flush_i) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (stall_s && drain_hit_s) begin
            state_nxt_s = ST_DRAIN;
          end else if (stall_s) begin
            state_nxt_s = ST_HAZ;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_HAZ, ST_DRAIN: begin
          if (!stall_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: state_nxt_s = ST_RUN;
      endcase
    end
  end

  // State, pending mask and counter registers; reset clears immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_RUN;
      pending_r <= {NUM_REGS{1'b0}};
      cnt_r     <= CNT_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb_scoreboard_ctrl
// Directed scenarios followed by random traffic, all compared against a
// behavioural model of the scoreboard rules (per-register pending flags and
// a producer count).
module tb_scoreboard_ctrl;
  import scoreboard_ctrl_pkg::*;

  localparam int MAXO = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  scoreboard_ctrl_if #(.MAX_OUTSTANDING(MAXO)) sb_if ();

  scoreboard_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  bit m_pend [32];
  int m_cnt;
  int m_state; // 0 run, 1 haz, 2 drain

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = 32'd0;
    for (int i = 1; i < 32; i++) if (m_pend[i]) m[i] = 1'b1;
    return m;
  endfunction

  function automatic bit m_clearing(input int r);
    return sb_if.wb_long_we_i && r != 0 && int'(sb_if.wb_long_waddr_i) == r && m_pend[r];
  endfunction

  function automatic bit m_busy(input int r);
    return r != 0 && m_pend[r] && !m_clearing(r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_cnt   = 0;
    m_state = 0;
  endtask

  task automatic idle();
    sb_if.id_valid_i      = 1'b0;
    sb_if.id_reg1_re_i    = 1'b0;
    sb_if.id_reg2_re_i    = 1'b0;
    sb_if.id_reg1_raddr_i = 5'd0;
    sb_if.id_reg2_raddr_i = 5'd0;
    sb_if.id_reg_we_i     = 1'b0;
    sb_if.id_reg_waddr_i  = 5'd0;
    sb_if.id_long_i       = 1'b0;
    sb_if.id_fence_i      = 1'b0;
    sb_if.wb_long_we_i    = 1'b0;
    sb_if.wb_long_waddr_i = 5'd0;
    sb_if.flush_i         = 1'b0;
  endtask

  task automatic load(input int rd);
    idle();
    sb_if.id_valid_i     = 1'b1;
    sb_if.id_long_i      = 1'b1;
    sb_if.id_reg_we_i    = 1'b1;
    sb_if.id_reg_waddr_i = 5'(rd);
  endtask

  task automatic read1(input int rs);
    idle();
    sb_if.id_valid_i      = 1'b1;
    sb_if.id_reg1_re_i    = 1'b1;
    sb_if.id_reg1_raddr_i = 5'(rs);
  endtask

  task automatic wb(input int rd);
    sb_if.wb_long_we_i    = 1'b1;
    sb_if.wb_long_waddr_i = 5'(rd);
  endtask

  // Inputs are stable; check combinational outputs, clock once, update the
  // model from the same inputs and check the registered state.
  task automatic cycle();
    bit e_stall, e_issue, e_drain, e_full, e_clr_any, e_inc, e_flush;
    bit any_after;
    int wa, wbr;
    #3;
    wa        = int'(sb_if.id_reg_waddr_i);
    wbr       = int'(sb_if.wb_long_waddr_i);
    e_clr_any = m_clearing(wbr);
    any_after = 1'b0;
    for (int i = 1; i < 32; i++) if (m_pend[i] && !m_clearing(i)) any_after = 1'b1;
    e_drain = sb_if.id_fence_i && any_after;
    e_full  = sb_if.id_long_i && m_cnt == MAXO && !e_clr_any;
    e_stall = sb_if.id_valid_i && !sb_if.flush_i &&
              ((sb_if.id_reg1_re_i && m_busy(int'(sb_if.id_reg1_raddr_i))) ||
               (sb_if.id_reg2_re_i && m_busy(int'(sb_if.id_reg2_raddr_i))) ||
               (sb_if.id_reg_we_i && m_busy(wa)) || e_full || e_drain);
    e_issue = sb_if.id_valid_i && !sb_if.flush_i && !e_stall;
    e_inc   = e_issue && sb_if.id_long_i && sb_if.id_reg_we_i && wa != 0;
    e_flush = sb_if.flush_i;
    chk("stall", 32'(sb_if.stall_o), 32'(e_stall));
    chk("issue", 32'(sb_if.issue_o), 32'(e_issue));
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (e_clr_any) begin m_pend[wbr] = 1'b0; m_cnt--; end
      if (e_inc)     begin m_pend[wa]  = 1'b1; m_cnt++; end
      if (e_flush)            m_state = 0;
      else if (m_state == 0)  m_state = e_stall ? (e_drain ? 2 : 1) : 0;
      else if (!e_stall)      m_state = 0;
    end
    chk("pending", sb_if.pending_o, m_mask());
    chk("outstanding", 32'(sb_if.outstanding_o), 32'(m_cnt));
    chk("state", 32'(dut.state_r), 32'(m_state));
  endtask

  // Explicit check of stall/issue before the edge (call before cycle()).
  task automatic probe(input string tag, input bit s, input bit i);
    #3;
    chk({tag, "_stall"}, 32'(sb_if.stall_o), 32'(s));
    chk({tag, "_issue"}, 32'(sb_if.issue_o), 32'(i));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #2;
    chk("rst_pending", sb_if.pending_o, 32'd0);
    chk("rst_outstanding", 32'(sb_if.outstanding_o), 32'd0);
    chk("rst_stall", 32'(sb_if.stall_o), 32'd0);
    @(posedge clk); #1;
    read1(3);
    probe("rst_read", 1'b0, 1'b1);
    cycle();
    rst = 1'b0;
    idle();
    cycle();

    // Load x5 then dependent read; forwarding on writeback
    load(5);            cycle();
    read1(5);           probe("raw", 1'b1, 1'b0); cycle();
    chk("raw_haz_state", 32'(dut.state_r), 32'(ST_HAZ));
    read1(5);           cycle();
    read1(5); wb(5);    probe("raw_fwd", 1'b0, 1'b1); cycle();
    chk("raw_cleared", sb_if.pending_o, 32'd0);

    // Producer budget full, then same-cycle retire
    for (int r = 1; r <= 4; r++) begin load(r); cycle(); end
    load(6);            probe("full", 1'b1, 1'b0);
    chk("full_cnt", 32'(sb_if.outstanding_o), 32'd4);
    cycle();
    load(6); wb(1);     probe("full_fwd", 1'b0, 1'b1); cycle();
    chk("full_fwd_cnt", 32'(sb_if.outstanding_o), 32'd4);
    chk("full_fwd_mask", sb_if.pending_o, 32'h0000_005C);
    foreach (m_pend[i]) ;
    idle(); wb(2); cycle(); idle(); wb(3); cycle();
    idle(); wb(4); cycle(); idle(); wb(6); cycle();
    chk("drained_cnt", 32'(sb_if.outstanding_o), 32'd0);

    // Fence waits for pending x7
    load(7);            cycle();
    idle(); sb_if.id_valid_i = 1'b1; sb_if.id_fence_i = 1'b1;
    probe("fence", 1'b1, 1'b0); cycle();
    chk("fence_state", 32'(dut.state_r), 32'(ST_DRAIN));
    wb(7);              probe("fence_wb", 1'b0, 1'b1); cycle();
    chk("fence_run", 32'(dut.state_r), 32'(ST_RUN));

    // x0 read and writeback to non-pending register
    load(8);            cycle();
    read1(0); wb(9);    probe("x0", 1'b0, 1'b1); cycle();
    chk("x9_mask", sb_if.pending_o, 32'h0000_0100);
    chk("x9_cnt", 32'(sb_if.outstanding_o), 32'd1);
    idle(); wb(8);      cycle();

    // Flush during HAZ
    load(10);           cycle();
    read1(10);          cycle();
    read1(10); sb_if.flush_i = 1'b1;
    probe("flush", 1'b0, 1'b0); cycle();
    chk("flush_state", 32'(dut.state_r), 32'(ST_RUN));
    chk("flush_mask", sb_if.pending_o, 32'h0000_0400);

    // Asynchronous reset with three pending
    load(11);           cycle();
    load(12);           cycle();
    chk("three_cnt", 32'(sb_if.outstanding_o), 32'd3);
    idle();
    #2; rst = 1'b1; #1;
    chk("async_pending", sb_if.pending_o, 32'd0);
    chk("async_cnt", 32'(sb_if.outstanding_o), 32'd0);
    model_reset();
    cycle();
    rst = 1'b0;
    cycle();

    // Random traffic on a small register window
    for (int n = 0; n < 400; n++) begin
      idle();
      sb_if.id_valid_i      = ($urandom_range(0, 3) != 0);
      sb_if.id_reg1_re_i    = $urandom_range(0, 1);
      sb_if.id_reg2_re_i    = $urandom_range(0, 1);
      sb_if.id_reg1_raddr_i = 5'($urandom_range(0, 7));
      sb_if.id_reg2_raddr_i = 5'($urandom_range(0, 7));
      sb_if.id_reg_we_i     = $urandom_range(0, 1);
      sb_if.id_reg_waddr_i  = 5'($urandom_range(0, 7));
      sb_if.id_long_i       = ($urandom_range(0, 2) == 0);
      sb_if.id_fence_i      = ($urandom_range(0, 9) == 0);
      sb_if.wb_long_we_i    = ($urandom_range(0, 2) == 0);
      sb_if.wb_long_waddr_i = 5'($urandom_range(0, 7));
      sb_if.flush_i         = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_ctrl.md
SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, SHALL set the maximum number of in-flight long-latency (load/div) producers.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset; SHALL be asynchronous and active-high.
REQ-004 id_valid_i  in  1  decode stage holds a valid instruction.
REQ-005 id_reg1_re_i / id_reg2_re_i  in  1 each  source-operand read enables from decode.
REQ-006 id_reg1_raddr_i / id_reg2_raddr_i  in  `RADDR_WIDTH each  source register addresses.
REQ-007 id_reg_we_i  in  1  decoded instruction writes rd.
REQ-008 id_reg_waddr_i  in  `RADDR_WIDTH  destination register address.
REQ-009 id_long_i  in  1  decoded instruction is a long-latency producer.
REQ-010 id_fence_i  in  1  decoded instruction requires all pending writes drained.
REQ-011 wb_long_we_i  in  1  a long-latency result writes back this cycle.
REQ-012 wb_long_waddr_i  in  `RADDR_WIDTH  writeback register of that result.
REQ-013 flush_i  in  1  pipeline flush (jump/exception).
REQ-014 stall_o  out  1  hold PC, IF/ID and suppress issue.
REQ-015 issue_o  out  1  decode instruction accepted this cycle.
REQ-016 pending_o  out  32  per-register pending-write mask.
REQ-017 outstanding_o  out  clog2(MAX_OUTSTANDING+1)  in-flight long-producer count.

Function
REQ-018 FSM states: RUN, HAZ, DRAIN; HAZ and DRAIN SHALL be entered only from RUN or each other as below.
REQ-019 clr[r] SHALL equal wb_long_we_i & (wb_long_waddr_i==r) & pending[r]; a register clearing this cycle SHALL count as ready (writeback forwarding).
REQ-020 raw_hit SHALL be (re1 & raddr1!=0 & pending[raddr1] & !clr[raddr1]) | same for port 2.
REQ-021 waw_hit SHALL be id_reg_we_i & waddr!=0 & pending[waddr] & !clr[waddr].
REQ-022 full_hit SHALL be id_long_i & (outstanding==MAX_OUTSTANDING) & !(any clr this cycle).
REQ-023 drain_hit SHALL be id_fence_i & (pending mask after clears != 0).
REQ-024 stall_o SHALL be combinational: id_valid_i & !flush_i & (raw_hit|waw_hit|full_hit|drain_hit); zero-cycle latency.
REQ-025 issue_o SHALL be id_valid_i & !flush_i & !stall_o.
REQ-026 Transitions: RUN->DRAIN on drain_hit; RUN->HAZ on other stall; HAZ/DRAIN->RUN when stall_o deasserts; any state->RUN on flush_i.
REQ-027 On issue_o & id_long_i & id_reg_we_i & waddr!=0, pending[waddr] SHALL set next cycle and outstanding SHALL increment.
REQ-028 On clr[r], pending[r] SHALL clear next cycle and outstanding SHALL decrement.
REQ-029 Simultaneous set and clear of different registers SHALL both apply; outstanding SHALL be unchanged.
REQ-030 wb_long_we_i to a non-pending register or x0 SHALL be ignored (no count change).
REQ-031 pending[0] SHALL be constant 0; outstanding SHALL never exceed MAX_OUTSTANDING nor underflow.
REQ-032 flush_i SHALL suppress issue only; pending and outstanding SHALL be preserved (in-flight producers still retire).

Reset
REQ-033 While rst high: state RUN, pending_o 0, outstanding_o 0; stall_o and issue_o SHALL follow REQ-024/025 from cleared state.
REQ-034 Reset mid-stall SHALL discard all pending entries immediately and asynchronously.

Structure
REQ-035 `RADDR_WIDTH, `ZERO_REG, `READ_ENABLE, `WRITE_ENABLE and the RUN/HAZ/DRAIN encodings SHALL live in defines.v.
REQ-036 One sub-module, hazard_chk, SHALL hold the combinational raw/waw hit logic; the FSM, mask and counter SHALL stay in scoreboard_ctrl.

Verification
REQ-037 Load to x5 issues, next cycle add reads x5 -> stall_o=1 until wb_long x5; same-cycle wb -> stall_o=0, issue_o=1.
REQ-038 Four loads to x1..x4 issue, fifth load to x6 -> stall_o=1, outstanding_o=4; wb x1 same cycle -> fifth issues, count stays 4.
REQ-039 Fence with pending x7 -> state DRAIN, stall_o=1; after wb x7 -> RUN, issue_o=1.
REQ-040 Read of x0 or wb_long to non-pending x9 -> no stall, pending_o and outstanding_o unchanged.
REQ-041 flush_i during HAZ -> issue_o=0, state RUN next cycle, pending_o unchanged.
REQ-042 rst asserted with three pending -> pending_o=0, outstanding_o=0 without a clock edge.
